// File: rtl/snow64_ext_dat_acc_arbiter.sv
// snow64_ext_dat_acc_arbiter
// Round-robin arbiter that merges NUM_CHANNELS internal requesters onto one
// Snow64 external data access port. One transaction is in flight at a time.
// An optional timeout completes a stalled transaction with an error.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   ch_req            : per-channel request level
//   ch_access_type    : per-channel access type (0 read, 1 write)
//   ch_addr, ch_wdata : packed per-channel address / write data (channel i at [i*W +: W])
//   ch_valid          : one-cycle completion pulse to the granted channel
//   ch_err            : completion was a timeout (qualified by ch_valid)
//   ch_rdata          : response data shared by all channels
//   ext_req           : external request level
//   ext_access_type, ext_addr, ext_data : latched fields of the granted request
//   ext_valid, ext_rdata : external completion pulse and response data
module snow64_ext_dat_acc_arbiter #(
    parameter int unsigned NUM_CHANNELS   = 4,
    parameter int unsigned ADDR_WIDTH     = 64,
    parameter int unsigned DATA_WIDTH     = 256,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_CHANNELS-1:0]            ch_req,
    input  logic [NUM_CHANNELS-1:0]            ch_access_type,
    input  logic [NUM_CHANNELS*ADDR_WIDTH-1:0] ch_addr,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] ch_wdata,
    output logic [NUM_CHANNELS-1:0]            ch_valid,
    output logic                               ch_err,
    output logic [DATA_WIDTH-1:0]              ch_rdata,
    output logic                               ext_req,
    output logic                               ext_access_type,
    output logic [ADDR_WIDTH-1:0]              ext_addr,
    output logic [DATA_WIDTH-1:0]              ext_data,
    input  logic                               ext_valid,
    input  logic [DATA_WIDTH-1:0]              ext_rdata
);

    localparam int unsigned LG_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [LG_W-1:0]  LAST_CH   = LG_W'(NUM_CHANNELS - 1);
    localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0] TMR_SAT   = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  r_state,        w_nxt_state;
    logic [LG_W-1:0]         r_last_grant,   w_nxt_last;
    logic [LG_W-1:0]         r_grant,        w_nxt_grant;
    logic [TMR_W-1:0]        r_timer,        w_nxt_timer;
    logic [NUM_CHANNELS-1:0] r_ch_valid,     w_nxt_ch_valid;
    logic                    r_ch_err,       w_nxt_ch_err;
    logic [DATA_WIDTH-1:0]   r_ch_rdata,     w_nxt_ch_rdata;
    logic                    r_ext_req,      w_nxt_ext_req;
    logic                    r_ext_type,     w_nxt_ext_type;
    logic [ADDR_WIDTH-1:0]   r_ext_addr,     w_nxt_ext_addr;
    logic [DATA_WIDTH-1:0]   r_ext_data,     w_nxt_ext_data;

    logic                    w_any_req;
    logic [LG_W-1:0]         w_cand;
    logic [LG_W-1:0]         w_pick;
    logic                    w_sel_type;
    logic [ADDR_WIDTH-1:0]   w_sel_addr;
    logic [DATA_WIDTH-1:0]   w_sel_data;
    logic [NUM_CHANNELS-1:0] w_grant_1h;
    logic                    w_timeout;

    // Round-robin pick: first requester found searching upward from last_grant+1.
    always_comb begin
        w_any_req = 1'b0;
        w_pick    = r_last_grant;
        w_cand    = '0;
        for (int i = 1; i <= int'(NUM_CHANNELS); i++) begin
            w_cand = LG_W'((int'(r_last_grant) + i) % int'(NUM_CHANNELS));
            if (!w_any_req && ch_req[w_cand]) begin
                w_any_req = 1'b1;
                w_pick    = w_cand;
            end
        end
    end

    // Field mux for the picked channel, and one-hot of the current grant.
    always_comb begin
        w_sel_type = 1'b0;
        w_sel_addr = '0;
        w_sel_data = '0;
        w_grant_1h = '0;
        for (int i = 0; i < int'(NUM_CHANNELS); i++) begin
            if (w_pick == LG_W'(i)) begin
                w_sel_type = ch_access_type[i];
                w_sel_addr = ch_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_data = ch_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
            w_grant_1h[i] = (r_grant == LG_W'(i));
        end
    end

    // r_timer holds the number of BUSY cycles already elapsed, so expiry
    // lands ch_valid TIMEOUT_CYCLES+1 cycles after ext_req first rose.
    assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_timer == TMR_LIMIT);

    // Next-state and next-output logic.
    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_last     = r_last_grant;
        w_nxt_grant    = r_grant;
        w_nxt_timer    = r_timer;
        w_nxt_ch_valid = r_ch_valid;
        w_nxt_ch_err   = r_ch_err;
        w_nxt_ch_rdata = r_ch_rdata;
        w_nxt_ext_req  = r_ext_req;
        w_nxt_ext_type = r_ext_type;
        w_nxt_ext_addr = r_ext_addr;
        w_nxt_ext_data = r_ext_data;

        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_nxt_grant    = w_pick;
                    w_nxt_ext_type = w_sel_type;
                    w_nxt_ext_addr = w_sel_addr;
                    w_nxt_ext_data = w_sel_data;
                    w_nxt_ext_req  = 1'b1;
                    w_nxt_timer    = '0;
                    w_nxt_state    = S_BUSY;
                end
            end
            S_BUSY: begin
                if (r_timer != TMR_SAT) begin
                    w_nxt_timer = r_timer + TMR_W'(1);
                end
                // ext_valid wins over a same-cycle timeout.
                if (ext_valid || w_timeout) begin
                    w_nxt_ch_rdata = ext_valid ? ext_rdata : '0;
                    w_nxt_ch_err   = ~ext_valid;
                    w_nxt_ch_valid = w_grant_1h;
                    w_nxt_ext_req  = 1'b0;
                    w_nxt_last     = r_grant;
                    w_nxt_state    = S_DONE;
                end
            end
            S_DONE: begin
                w_nxt_ch_valid = '0;
                w_nxt_ch_err   = 1'b0;
                w_nxt_state    = S_IDLE;
            end
            default: begin
                w_nxt_state = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_last_grant <= LAST_CH;
            r_grant      <= '0;
            r_timer      <= '0;
            r_ch_valid   <= '0;
            r_ch_err     <= 1'b0;
            r_ch_rdata   <= '0;
            r_ext_req    <= 1'b0;
            r_ext_type   <= 1'b0;
            r_ext_addr   <= '0;
            r_ext_data   <= '0;
        end else begin
            r_state      <= w_nxt_state;
            r_last_grant <= w_nxt_last;
            r_grant      <= w_nxt_grant;
            r_timer      <= w_nxt_timer;
            r_ch_valid   <= w_nxt_ch_valid;
            r_ch_err     <= w_nxt_ch_err;
            r_ch_rdata   <= w_nxt_ch_rdata;
            r_ext_req    <= w_nxt_ext_req;
            r_ext_type   <= w_nxt_ext_type;
            r_ext_addr   <= w_nxt_ext_addr;
            r_ext_data   <= w_nxt_ext_data;
        end
    end

    assign ch_valid        = r_ch_valid;
    assign ch_err          = r_ch_err;
    assign ch_rdata        = r_ch_rdata;
    assign ext_req         = r_ext_req;
    assign ext_access_type = r_ext_type;
    assign ext_addr        = r_ext_addr;
    assign ext_data        = r_ext_data;

endmodule
